txdata_arbiter: RTL and testbench

- Round-robin arbiter that shares one hex-dump serial printer among NREQ requesters. The printer is the 32-bit-word-to-"x%08X\r\n" UART formatter.
- Each requester gets a one-deep holding slot. The arbiter sequences the printer's strobe/busy handshake so that words never interleave and no requester starves.
- Sits between debug/status sources (counters, bus snoopers) and the single printer instance driving the UART pin.

---
 rtl/txdata_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_txdata_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txdata_arbiter.sv
// ----------------------------------------------------------------------------
// txdata_arbiter
//
// Round-robin arbiter that lets NREQ debug/status sources share one hex-dump
// printer (the 32-bit word -> "x%08X\r\n" UART formatter). Each requester
// owns a one-deep holding slot. The arbiter runs the printer's strobe/busy
// handshake so that whole words never interleave and no requester starves.
//
// Handshake (both sides):
//   Requester side: i_req_stb[k] is a one-cycle write strobe. It is accepted
//   only when slot k is free (o_req_busy[k] == 0). A strobe while the slot is
//   occupied is dropped and leaves the held word untouched.
//   Printer side: o_tx_stb is raised with o_tx_data/o_grant stable and is held
//   until i_tx_busy is sampled high. The printer is then owned until
//   i_tx_busy is sampled low again. A new word is only offered when
//   i_tx_busy was low at the issuing edge.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   DW    word width, matches the printer data width
//   IDW   grant index width, 2**IDW >= NREQ
//
// Ports:
//   i_clk, i_reset    clock, asynchronous active-high reset
//   i_req_stb         per-requester write strobe
//   i_req_data        packed words, requester k on [k*DW +: DW]
//   o_req_busy        slot occupied flags (registered)
//   o_tx_stb          strobe to the printer
//   o_tx_data         word to the printer
//   i_tx_busy         printer busy
//   o_grant           index of the requester being printed
//   o_busy            any slot pending or FSM not idle
//   o_dbg_state       FSM state: 0 IDLE, 1 ISSUE, 2 WAIT_DONE
//
// Optional feature (macro TXARB_DROP_CNT_EN):
//   i_drop_clr        synchronous clear of the drop counter (wins over increments)
//   o_drop_cnt        saturating count of dropped strobes over all requesters
// ----------------------------------------------------------------------------
module txdata_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_stb,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_busy,
  output logic              o_tx_stb,
  output logic [DW-1:0]     o_tx_data,
  input  logic              i_tx_busy,
  output logic [IDW-1:0]    o_grant,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
`ifdef TXARB_DROP_CNT_EN
  ,
  input  logic              i_drop_clr,
  output logic [15:0]       o_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [NREQ-1:0]   pending;
  logic [DW-1:0]     slot [NREQ];
  logic [IDW-1:0]    last;

  logic [IDW-1:0]    winner;
  logic [DW-1:0]     winner_data;
  int                best_dist;
  int                dist_k;

  logic              do_issue;
  logic              do_ack;

  // --------------------------------------------------------------------------
  // Round-robin search: the winner is the pending slot with the smallest
  // distance after 'last' (last+1 has distance 0). Done as a min-distance
  // scan so no variable-width indexing into the slot arrays is needed.
  // --------------------------------------------------------------------------
  always_comb begin
    winner    = '0;
    best_dist = NREQ;
    dist_k    = 0;
    for (int k = 0; k < NREQ; k++) begin
      dist_k = (k + NREQ - 1 - int'(last)) % NREQ;
      if (pending[k] && (dist_k < best_dist)) begin
        best_dist = dist_k;
        winner    = IDW'(k);
      end
    end
  end

  always_comb begin
    winner_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == IDW'(k)) begin
        winner_data = slot[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if ((|pending) && !i_tx_busy) state_nxt = ST_ISSUE;
      ST_ISSUE:     if (i_tx_busy)                state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!i_tx_busy)               state_nxt = ST_IDLE;
      default:                                    state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    do_issue = 1'b0;
    do_ack   = 1'b0;
    case (state)
      ST_IDLE:  do_issue = (|pending) && !i_tx_busy;
      ST_ISSUE: do_ack   = i_tx_busy;
      default: begin
        do_issue = 1'b0;
        do_ack   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Slot occupancy and printer-side registers.
  // A slot is only cleared while it is pending, and only captured while it is
  // free, so capture and clear never collide on the same slot. A slot written
  // at this edge is not visible to the grant search until the next edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pending   <= '0;
      o_tx_stb  <= 1'b0;
      o_tx_data <= '0;
      o_grant   <= '0;
      last      <= IDW'(NREQ - 1);
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (i_req_stb[k] && !pending[k]) begin
          pending[k] <= 1'b1;
        end else if (do_ack && (o_grant == IDW'(k))) begin
          pending[k] <= 1'b0;
        end
      end
      if (do_issue) begin
        o_grant   <= winner;
        o_tx_data <= winner_data;
        o_tx_stb  <= 1'b1;
        last      <= winner;
      end
      if (do_ack) begin
        o_tx_stb <= 1'b0;
      end
    end
  end

  // Slot payloads carry no control meaning, so they are not reset.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NREQ; k++) begin
      if (i_req_stb[k] && !pending[k]) begin
        slot[k] <= i_req_data[k*DW +: DW];
      end
    end
  end

  assign o_req_busy  = pending;
  assign o_busy      = (|pending) || (state != ST_IDLE);
  assign o_dbg_state = state;

`ifdef TXARB_DROP_CNT_EN
  // --------------------------------------------------------------------------
  // Drop counter: strobes hitting an occupied slot this cycle, summed and
  // saturated at all-ones. Clear wins over increments in the same cycle.
  // --------------------------------------------------------------------------
  logic [NREQ-1:0] drop_vec;
  logic [16:0]     drop_sum;

  assign drop_vec = i_req_stb & pending;
  assign drop_sum = {1'b0, o_drop_cnt} + 17'($countones(drop_vec));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_drop_cnt <= '0;
    end else if (i_drop_clr) begin
      o_drop_cnt <= '0;
    end else if (drop_sum[16]) begin
      o_drop_cnt <= 16'hFFFF;
    end else begin
      o_drop_cnt <= drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_txdata_arbiter.sv
// ----------------------------------------------------------------------------
// tb_txdata_arbiter
//
// Bench for txdata_arbiter with a printer model (random busy length), a
// behavioural reference of the arbiter compared every cycle, a queue of the
// words the printer must receive, and directed scenarios with literal
// expectations followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_txdata_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_WAIT  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_stb;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_busy;
  logic               tx_stb;
  logic [DW-1:0]      tx_data;
  logic               tx_busy;
  logic [IDW-1:0]     grant;
  logic               busy;
  logic [1:0]         dbg_state;
`ifdef TXARB_DROP_CNT_EN
  logic               drop_clr;
  logic [15:0]        drop_cnt;
`endif

  txdata_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_stb   (req_stb),
    .i_req_data  (req_data),
    .o_req_busy  (req_busy),
    .o_tx_stb    (tx_stb),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
`ifdef TXARB_DROP_CNT_EN
    ,
    .i_drop_clr  (drop_clr),
    .o_drop_cnt  (drop_cnt)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- printer model ----------------
  logic          prn_busy = 1'b0;
  int            prn_left = 0;
  logic          force_busy;
  logic [DW-1:0] exp_q[$];
  int            log_grant[$];
  logic [DW-1:0] log_data[$];

  assign tx_busy = prn_busy | force_busy;

  always @(posedge clk) begin
    if (!prn_busy && !force_busy && tx_stb) begin
      prn_busy <= 1'b1;
      prn_left <= $urandom_range(1, 4);
      log_grant.push_back(int'(grant));
      log_data.push_back(tx_data);
      if (exp_q.size() == 0) begin
        chk("print_unexpected", 64'(tx_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("print_word", 64'(tx_data), 64'(exp_q.pop_front()));
      end
    end else if (prn_busy) begin
      if (prn_left <= 1) prn_busy <= 1'b0;
      prn_left <= prn_left - 1;
    end
  end

  // ---------------- behavioural reference ----------------
  bit            m_pend [NREQ];
  logic [DW-1:0] m_slot [NREQ];
  int            m_last;
  int            m_phase;
  logic          m_stb;
  logic [DW-1:0] m_data;
  int            m_grant;
  int            m_drop;
  bit            p_old  [NREQ];
  int            n_drop;
  int            w;

  // Next requester in round-robin order after 'last_i' that holds a word.
  function automatic int rr_pick(input bit p [NREQ], input int last_i);
    for (int i = 1; i <= NREQ; i++) begin
      int idx = (last_i + i) % NREQ;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] pack_pend(input bit p [NREQ]);
    logic [NREQ-1:0] v = '0;
    for (int i = 0; i < NREQ; i++) v[i] = p[i];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
      m_last  = NREQ - 1;
      m_phase = M_IDLE;
      m_stb   = 1'b0;
      m_data  = '0;
      m_grant = 0;
      m_drop  = 0;
      exp_q.delete();
    end else begin
      p_old  = m_pend;
      n_drop = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (req_stb[k]) begin
          if (p_old[k]) n_drop++;
          else begin
            m_pend[k] = 1'b1;
            m_slot[k] = req_data[k*DW +: DW];
          end
        end
      end
      if (m_phase == M_IDLE) begin
        w = rr_pick(p_old, m_last);
        if (w >= 0 && !tx_busy) begin
          m_grant = w;
          m_data  = m_slot[w];
          m_stb   = 1'b1;
          m_last  = w;
          m_phase = M_ISSUE;
          exp_q.push_back(m_data);
        end
      end else if (m_phase == M_ISSUE) begin
        if (tx_busy) begin
          m_stb           = 1'b0;
          m_pend[m_grant] = 1'b0;
          m_phase         = M_WAIT;
        end
      end else begin
        if (!tx_busy) m_phase = M_IDLE;
      end
`ifdef TXARB_DROP_CNT_EN
      if (drop_clr) m_drop = 0;
      else          m_drop = (m_drop + n_drop > 65535) ? 65535 : m_drop + n_drop;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  logic busy_at_edge = 1'b0;
  logic stb_prev     = 1'b0;
  always @(posedge clk) busy_at_edge <= tx_busy;

  always @(negedge clk) begin
    chk("tx_stb",    64'(tx_stb),   64'(m_stb));
    chk("tx_data",   64'(tx_data),  64'(m_data));
    chk("grant",     64'(grant),    64'(m_grant));
    chk("req_busy",  64'(req_busy), 64'(pack_pend(m_pend)));
    chk("busy",      64'(busy),     64'((|pack_pend(m_pend)) || (m_phase != M_IDLE)));
    chk("state_idle", 64'(dbg_state == 2'd0), 64'(m_phase == M_IDLE));
`ifdef TXARB_DROP_CNT_EN
    chk("drop_cnt",  64'(drop_cnt), 64'(m_drop));
`endif
    if (tx_stb && !stb_prev && !rst) chk("stb_rise_while_busy", 64'(busy_at_edge), 64'd0);
    stb_prev = tx_stb;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int k, input logic [DW-1:0] d);
    req_stb[k] = 1'b1;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (m_phase == M_IDLE) && !m_stb && (pack_pend(m_pend) == '0) &&
             !tx_busy && (exp_q.size() == 0);
    end
    chk({name, "_done"}, 64'(done), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int stb_seen;
  int lastpos [NREQ];
  int maxgap  [NREQ];
  bit seen_g1;

  initial begin
    rst        = 1'b1;
    req_stb    = '0;
    req_data   = '0;
    force_busy = 1'b0;
`ifdef TXARB_DROP_CNT_EN
    drop_clr   = 1'b0;
`endif
    @(negedge clk);
    chk("rst_tx_stb",   64'(tx_stb),   64'd0);
    chk("rst_req_busy", 64'(req_busy), 64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_grant",    64'(grant),    64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1. single request
    log_grant.delete(); log_data.delete();
    put(0, 32'h1234_5678);
    tick();
    req_stb = '0;
    @(negedge clk);
    chk("t1_pending",  64'(req_busy), 64'h1);
    chk("t1_stb_early", 64'(tx_stb),  64'd0);
    @(negedge clk);
    chk("t1_stb",   64'(tx_stb),  64'd1);
    chk("t1_data",  64'(tx_data), 64'h1234_5678);
    chk("t1_grant", 64'(grant),   64'd0);
    wait_quiet("t1", 100);
    @(negedge clk);
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_count",    64'(log_data.size()), 64'd1);
    if (log_data.size() >= 1) chk("t1_word", 64'(log_data[0]), 64'h1234_5678);

    // 2. round robin: two full bursts, then RR beats arrival order
    pulse_reset();
    wait_quiet("t2_rst", 100);
    for (int b = 0; b < 2; b++) begin
      log_grant.delete(); log_data.delete();
      for (int k = 0; k < NREQ; k++) put(k, 32'hA000_0000 + DW'(k));
      tick();
      req_stb = '0;
      wait_quiet("t2_burst", 200);
      chk("t2_count", 64'(log_grant.size()), 64'd4);
      for (int k = 0; k < NREQ && k < log_grant.size(); k++) begin
        chk("t2_order", 64'(log_grant[k]), 64'(k));
        chk("t2_word",  64'(log_data[k]),  64'(32'hA000_0000 + k));
      end
    end
    log_grant.delete(); log_data.delete();
    put(0, 32'hB000_0000); put(1, 32'hB000_0001);
    tick();
    req_stb = '0;
    seen_g1 = 1'b0;
    for (int i = 0; i < 100 && !seen_g1; i++) begin
      tick();
      seen_g1 = (m_phase == M_ISSUE) && (m_grant == 1);
    end
    chk("t2_reach_g1", 64'(seen_g1), 64'd1);
    put(3, 32'hB000_0003);
    tick();
    req_stb = '0;
    put(2, 32'hB000_0002);
    tick();
    req_stb = '0;
    wait_quiet("t2_rr", 200);
    chk("t2_rr_count", 64'(log_grant.size()), 64'd4);
    if (log_grant.size() == 4) begin
      chk("t2_rr_g2", 64'(log_grant[2]), 64'd2);
      chk("t2_rr_g3", 64'(log_grant[3]), 64'd3);
    end

    // 3. drop while pending
`ifdef TXARB_DROP_CNT_EN
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
`endif
    log_grant.delete(); log_data.delete();
    put(1, 32'h1);
    tick();
    put(1, 32'h2);
    tick();
    req_stb = '0;
    wait_quiet("t3", 100);
    chk("t3_count", 64'(log_data.size()), 64'd1);
    if (log_data.size() >= 1) chk("t3_word", 64'(log_data[0]), 64'h1);
`ifdef TXARB_DROP_CNT_EN
    @(negedge clk);
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
    tick();
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    @(negedge clk);
    chk("t3_drop_clr", 64'(drop_cnt), 64'd0);
`endif

    // 4. printer busy when the request arrives
    log_grant.delete(); log_data.delete();
    force_busy = 1'b1;
    put(3, 32'hDEAD_BEEF);
    tick();
    req_stb = '0;
    stb_seen = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (tx_stb) stb_seen++;
      tick();
    end
    chk("t4_no_stb_while_busy", 64'(stb_seen), 64'd0);
    force_busy = 1'b0;
    wait_quiet("t4", 100);
    chk("t4_count", 64'(log_data.size()), 64'd1);
    if (log_data.size() >= 1) begin
      chk("t4_word",  64'(log_data[0]),  64'hDEAD_BEEF);
      chk("t4_grant", 64'(log_grant[0]), 64'd3);
    end

    // 5. asynchronous reset while issuing with two words pending
    log_grant.delete(); log_data.delete();
    put(0, 32'hC000_0000); put(2, 32'hC000_0002);
    tick();
    req_stb = '0;
    seen_g1 = 1'b0;
    for (int i = 0; i < 50 && !seen_g1; i++) begin
      @(negedge clk);
      seen_g1 = tx_stb;
    end
    chk("t5_reach_issue", 64'(seen_g1), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_stb",      64'(tx_stb),   64'd0);
    chk("t5_rst_req_busy", 64'(req_busy), 64'd0);
    chk("t5_rst_busy",     64'(busy),     64'd0);
    tick();
    rst = 1'b0;
    put(1, 32'hC000_0001);
    tick();
    req_stb = '0;
    wait_quiet("t5", 100);
    chk("t5_count", 64'(log_grant.size()), 64'd2);
    if (log_grant.size() == 2) begin
      chk("t5_first",  64'(log_grant[0]), 64'd0);
      chk("t5_second", 64'(log_grant[1]), 64'd1);
      chk("t5_word",   64'(log_data[1]),  64'hC000_0001);
    end

    // 6. starvation: 0, 1 and 3 re-strobe every cycle
    pulse_reset();
    wait_quiet("t6_rst", 100);
    log_grant.delete(); log_data.delete();
    for (int i = 0; i < 80; i++) begin
      put(0, $urandom()); put(1, $urandom()); put(3, $urandom());
      tick();
    end
    req_stb = '0;
    wait_quiet("t6", 100);
    chk("t6_enough", 64'(log_grant.size() >= 6), 64'd1);
    if (log_grant.size() >= 6) begin
      chk("t6_g0", 64'(log_grant[0]), 64'd0);
      chk("t6_g1", 64'(log_grant[1]), 64'd1);
      chk("t6_g2", 64'(log_grant[2]), 64'd3);
      chk("t6_g3", 64'(log_grant[3]), 64'd0);
      chk("t6_g4", 64'(log_grant[4]), 64'd1);
      chk("t6_g5", 64'(log_grant[5]), 64'd3);
    end
    for (int k = 0; k < NREQ; k++) begin
      lastpos[k] = -1;
      maxgap[k]  = 0;
    end
    for (int i = 0; i < log_grant.size(); i++) begin
      int g = log_grant[i];
      if (lastpos[g] >= 0 && (i - lastpos[g]) > maxgap[g]) maxgap[g] = i - lastpos[g];
      lastpos[g] = i;
    end
    chk("t6_gap0", 64'(maxgap[0] <= NREQ), 64'd1);
    chk("t6_gap1", 64'(maxgap[1] <= NREQ), 64'd1);
    chk("t6_gap3", 64'(maxgap[3] <= NREQ), 64'd1);

    // 7. randomized traffic
    for (int i = 0; i < 1500; i++) begin
      req_stb = '0;
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if ($urandom_range(0, 1) == 1) put(k, $urandom());
        end
      end
`ifdef TXARB_DROP_CNT_EN
      drop_clr = ($urandom_range(0, 60) == 0);
`endif
      tick();
    end
    req_stb = '0;
`ifdef TXARB_DROP_CNT_EN
    drop_clr = 1'b0;
`endif
    wait_quiet("t7", 200);
    chk("t7_exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
